// File: rtl/rast_bbox.sv
// Micropolygon bounding-box stage: min/max, screen clamp, subsample-grid snap, empty-box reject.
// Optional backface culling is enabled by defining BBOX_BACKFACE_CULL_EN.
module rast_bbox #(
    parameter int SIGFIG    = 24,
    parameter int RADIX     = 10,
    parameter int VERTS     = 3,
    parameter int AXIS      = 3,
    parameter int COLORS    = 3,
    parameter int PIPES_BOX = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [VERTS*AXIS*SIGFIG-1:0]     tri_in,
    input  logic [COLORS*SIGFIG-1:0]         color_in,
    input  logic                             valid_in,
    input  logic [2*SIGFIG-1:0]              screen,
    input  logic [3:0]                       subsample,
    input  logic                             halt_in,
    output logic                             halt_out,
    output logic [VERTS*AXIS*SIGFIG-1:0]     tri_out,
    output logic [COLORS*SIGFIG-1:0]         color_out,
    output logic [4*SIGFIG-1:0]              box_out,
    output logic                             valid_out,
    output logic [15:0]                      drop_count
);
    localparam int TW = VERTS * AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam int BW = 4 * SIGFIG;

    // Handshake: a polygon is accepted on a rising edge where valid_in=1 and halt_in=0;
    // while halt_in=1 the whole pipe freezes and upstream must hold its polygon.
    assign halt_out = halt_in;

    logic signed [SIGFIG-1:0] min_x, min_y, max_x, max_y, vx, vy;
    logic signed [SIGFIG-1:0] lo_x, lo_y, hi_x, hi_y;
    logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
    logic signed [SIGFIG-1:0] scr_w, scr_h;
    logic        [SIGFIG-1:0] grid_mask;
    logic                     box_empty, cull, reject;

    always_comb begin
        min_x = tri_in[0 +: SIGFIG];
        min_y = tri_in[SIGFIG +: SIGFIG];
        max_x = min_x;
        max_y = min_y;
        vx    = '0;
        vy    = '0;
        for (int i = 1; i < VERTS; i++) begin
            vx = tri_in[(i*AXIS)*SIGFIG +: SIGFIG];
            vy = tri_in[(i*AXIS+1)*SIGFIG +: SIGFIG];
            if (vx < min_x) min_x = vx;
            if (vx > max_x) max_x = vx;
            if (vy < min_y) min_y = vy;
            if (vy > max_y) max_y = vy;
        end

        scr_w = screen[0 +: SIGFIG];
        scr_h = screen[SIGFIG +: SIGFIG];
        lo_x  = (min_x < 0) ? '0 : min_x;
        lo_y  = (min_y < 0) ? '0 : min_y;
        hi_x  = (max_x > scr_w) ? scr_w : max_x;
        hi_y  = (max_y > scr_h) ? scr_h : max_y;

        // Non-one-hot subsample codes fall back to whole-pixel snapping.
        case (subsample)
            4'b0100: grid_mask = '1 << (RADIX - 1);
            4'b0010: grid_mask = '1 << (RADIX - 2);
            4'b0001: grid_mask = '1 << (RADIX - 3);
            default: grid_mask = '1 << RADIX;
        endcase

        ll_x      = lo_x & grid_mask;
        ll_y      = lo_y & grid_mask;
        ur_x      = hi_x & grid_mask;
        ur_y      = hi_y & grid_mask;
        box_empty = (ur_x < ll_x) || (ur_y < ll_y);
    end

`ifdef BBOX_BACKFACE_CULL_EN
    localparam int AW = 2 * SIGFIG + 1;

    function automatic logic signed [AW-1:0] sext(input logic [SIGFIG-1:0] v);
        return {{(AW-SIGFIG){v[SIGFIG-1]}}, v};
    endfunction

    logic signed [AW-1:0] e1x, e1y, e2x, e2y, area;

    // Counter-clockwise (positive area) polygons face the viewer.
    always_comb begin
        e1x  = sext(tri_in[(1*AXIS)*SIGFIG +: SIGFIG])   - sext(tri_in[0 +: SIGFIG]);
        e1y  = sext(tri_in[(1*AXIS+1)*SIGFIG +: SIGFIG]) - sext(tri_in[SIGFIG +: SIGFIG]);
        e2x  = sext(tri_in[(2*AXIS)*SIGFIG +: SIGFIG])   - sext(tri_in[0 +: SIGFIG]);
        e2y  = sext(tri_in[(2*AXIS+1)*SIGFIG +: SIGFIG]) - sext(tri_in[SIGFIG +: SIGFIG]);
        area = e1x * e2y - e1y * e2x;
        cull = (area <= 0);
    end
`else
    assign cull = 1'b0;
`endif

    assign reject = box_empty | cull;

    logic [PIPES_BOX-1:0] v_q;
    logic [TW-1:0]        tri_q [PIPES_BOX];
    logic [CW-1:0]        col_q [PIPES_BOX];
    logic [BW-1:0]        box_q [PIPES_BOX];
    logic                 drop_into_last;

    // Rejects travel as bubbles plus a drop tag, counted as they enter the last stage.
    if (PIPES_BOX > 1) begin : g_drop_pipe
        logic [PIPES_BOX-2:0] d_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
            end else if (!halt_in) begin
                d_q[0] <= valid_in & reject;
                for (int i = 1; i < PIPES_BOX - 1; i++) d_q[i] <= d_q[i-1];
            end
        end
        assign drop_into_last = d_q[PIPES_BOX-2];
    end else begin : g_drop_direct
        assign drop_into_last = valid_in & reject;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            drop_count <= '0;
            for (int i = 0; i < PIPES_BOX; i++) begin
                tri_q[i] <= '0;
                col_q[i] <= '0;
                box_q[i] <= '0;
            end
        end else if (!halt_in) begin
            v_q[0]   <= valid_in & ~reject;
            tri_q[0] <= tri_in;
            col_q[0] <= color_in;
            box_q[0] <= {ur_y, ur_x, ll_y, ll_x};
            for (int i = 1; i < PIPES_BOX; i++) begin
                v_q[i]   <= v_q[i-1];
                tri_q[i] <= tri_q[i-1];
                col_q[i] <= col_q[i-1];
                box_q[i] <= box_q[i-1];
            end
            if (drop_into_last && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    assign valid_out = v_q[PIPES_BOX-1];
    assign tri_out   = tri_q[PIPES_BOX-1];
    assign color_out = col_q[PIPES_BOX-1];
    assign box_out   = box_q[PIPES_BOX-1];

endmodule
